uart_tx: RTL and testbench

Buffered 8N1 UART transmitter with a hardware flow-control gate, the transmit counterpart of the receive path feeding the seven-segment debug display. A byte producer pushes bytes over a valid/ready handshake into an internal FIFO. A bit-timing state machine serialises the bytes LSB-first onto the line toward the BLE module (`ble_uart_rx`). A new frame starts only while the module's clear-to-send input is asserted.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding and constants for the tx/rx paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_BAUD_115200_74M = 645;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q;
    logic [c_PTR_W-1:0] w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q;
    logic [c_PTR_W-1:0] w_rd_ptr_d;
    logic [c_LVL_W-1:0] r_level_q;
    logic [c_LVL_W-1:0] w_level_d;

    // Callers gate push on not-full and pop on not-empty; DEPTH is a power
    // of two so the pointers wrap by plain overflow.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   w_level_d = r_level_q + c_LVL_W'(1);
            2'b01:   w_level_d = r_level_q - c_LVL_W'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem_q[r_wr_ptr_q] <= din;
        end
    end

    assign dout  = r_mem_q[r_rd_ptr_q];
    assign level = r_level_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Buffered 8N1 UART transmitter, frame start gated by CTS.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_COUNT = UART_BAUD_115200_74M,
    parameter int DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic                   cts_n,
    output logic                   tx,
    output logic                   busy_out,
    output logic [$clog2(DEPTH):0] level_out
);

    localparam int c_LVL_W  = $clog2(DEPTH) + 1;
    localparam int c_BAUD_W = $clog2(BAUD_COUNT);
    localparam int c_BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_COUNT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(UART_DATA_BITS - 1);

    uart_state_t         r_state_q;
    uart_state_t         w_state_d;
    logic [c_BAUD_W-1:0] r_baud_q;
    logic [c_BAUD_W-1:0] w_baud_d;
    logic [c_BIT_W-1:0]  r_bit_q;
    logic [c_BIT_W-1:0]  w_bit_d;
    logic [7:0]          r_shift_q;
    logic [7:0]          w_shift_d;
    logic                r_tx_q;
    logic                w_tx_d;
    logic                r_cts_meta_q;
    logic                r_cts_sync_q;

    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_fifo_dout;
    logic [c_LVL_W-1:0]  w_level;
    logic                w_can_start;
    logic                w_baud_last;

    assign ready_out   = (w_level != c_LVL_W'(DEPTH));
    assign w_push      = valid_in & ready_out;
    assign w_can_start = (w_level != '0) & ~r_cts_sync_q;
    assign w_baud_last = (r_baud_q == c_BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (data_in),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .level (w_level)
    );

    // Synchroniser resets to "not clear" so no frame starts before CTS is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cts_meta_q <= 1'b1;
            r_cts_sync_q <= 1'b1;
        end else begin
            r_cts_meta_q <= cts_n;
            r_cts_sync_q <= r_cts_meta_q;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_baud_d  = r_baud_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_pop     = 1'b0;
        w_tx_d    = 1'b1;
        if (r_state_q != IDLE) begin
            w_baud_d = w_baud_last ? '0 : r_baud_q + c_BAUD_W'(1);
        end
        case (r_state_q)
            IDLE: begin
                w_baud_d = '0;
                w_bit_d  = '0;
                if (w_can_start) begin
                    w_pop     = 1'b1;
                    w_shift_d = w_fifo_dout;
                    w_state_d = START;
                end
            end
            START: begin
                w_tx_d = 1'b0;
                if (w_baud_last) begin
                    w_bit_d   = '0;
                    w_state_d = DATA;
                end
            end
            DATA: begin
                w_tx_d = r_shift_q[0];
                if (w_baud_last) begin
                    w_shift_d = {1'b0, r_shift_q[7:1]};
                    w_bit_d   = r_bit_q + c_BIT_W'(1);
                    if (r_bit_q == c_BIT_LAST) begin
                        w_state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    if (w_can_start) begin
                        w_pop     = 1'b1;
                        w_shift_d = w_fifo_dout;
                        w_state_d = START;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // The line level is registered from the current state, so it trails the
    // state register by one cycle while keeping every bit exactly BAUD_COUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= IDLE;
            r_baud_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_tx_q    <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_baud_q  <= w_baud_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_tx_q    <= w_tx_d;
        end
    end

    assign tx        = r_tx_q;
    assign busy_out  = (r_state_q != IDLE);
    assign level_out = w_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx with a line-decoding UART monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [7:0]    data_in;
    logic          valid_in;
    logic          ready_out;
    logic          cts_n;
    logic          tx;
    logic          busy_out;
    logic [LW-1:0] level_out;

    int            checks;
    int            errors;
    int            cyc;
    int            busy_total;
    logic          mon_busy;
    logic [7:0]    sb[$];
    int            start_edges[$];

    uart_tx #(
        .BAUD_COUNT (BAUD),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .cts_n     (cts_n),
        .tx        (tx),
        .busy_out  (busy_out),
        .level_out (level_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy_out === 1'b1) busy_total <= busy_total + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until_cyc(input int target);
        while (cyc < target) step();
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic push_wait(input logic [7:0] b, output int edge_n);
        logic r;
        bit   done;
        done     = 0;
        edge_n   = -1;
        valid_in = 1'b1;
        data_in  = b;
        for (int k = 0; k < 1000 && !done; k++) begin
            r = ready_out;
            step();
            if (r) begin
                done   = 1;
                edge_n = cyc;
                sb.push_back(b);
            end
        end
        valid_in = 1'b0;
        data_in  = 8'h00;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic push_try(input logic [7:0] b, output logic acc);
        acc      = ready_out;
        valid_in = 1'b1;
        data_in  = b;
        step();
        valid_in = 1'b0;
        data_in  = 8'h00;
        if (acc) sb.push_back(b);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            step();
            if (sb.size() == 0 && !mon_busy && busy_out === 1'b0 && level_out == '0) done = 1;
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_starts(input int n);
        for (int k = 0; k < 500 && start_edges.size() < n; k++) step();
        if (start_edges.size() < n) check("start_timeout", start_edges.size(), n);
    endtask

    // Reference UART receiver: an 8N1 frame is 0, data LSB-first, 1, each bit
    // held for exactly BAUD cycles; decoded bytes must match the scoreboard.
    initial begin : p_monitor
        logic [10*BAUD-1:0] smp;
        logic [7:0]         dec;
        logic [7:0]         exp_b;
        bit                 have_exp;
        bit                 aborted;
        int                 unstable;
        mon_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                aborted  = 0;
                start_edges.push_back(cyc);
                have_exp = (sb.size() != 0);
                exp_b    = 8'h00;
                if (have_exp) exp_b = sb.pop_front();
                for (int i = 0; i < 10 * BAUD; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1;
                        break;
                    end
                    smp[i] = tx;
                end
                if (!aborted) begin
                    unstable = 0;
                    for (int b = 0; b < 10; b++) begin
                        for (int s = 1; s < BAUD; s++) begin
                            if (smp[b*BAUD+s] !== smp[b*BAUD]) unstable++;
                        end
                    end
                    for (int b = 0; b < 8; b++) dec[b] = smp[(b+1)*BAUD + BAUD/2];
                    check("frame_expected", int'(have_exp), 1);
                    check("bit_stability", unstable, 0);
                    check("start_bit", int'(smp[BAUD/2]), 0);
                    check("stop_bit", int'(smp[9*BAUD + BAUD/2]), 1);
                    if (have_exp) check("data_byte", int'(dec), int'(exp_b));
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : p_watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin : p_stim
        int            n;
        int            base;
        int            busy0;
        int            s0;
        int            r_edge;
        logic          acc;
        logic [7:0]    fb [5];
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        busy_total = 0;
        rst_n      = 1'b0;
        cts_n      = 1'b0;
        valid_in   = 1'b0;
        data_in    = 8'h00;
        repeat (3) step();
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy_out), 0);
        check("rst_level", int'(level_out), 0);
        check("rst_ready", int'(ready_out), 1);
        rst_n = 1'b1;
        repeat (3) step();

        // Single byte: start bit two edges after the accepting edge.
        base  = start_edges.size();
        busy0 = busy_total;
        push_wait(8'h55, n);
        wait_idle();
        check("single_frames", start_edges.size() - base, 1);
        if (start_edges.size() > base) check("single_latency", start_edges[base] - n, 2);
        check("single_busy_cycles", busy_total - busy0, 10 * BAUD);

        // Back-to-back frames with no idle gap.
        base = start_edges.size();
        push_wait(8'hA3, n);
        push_wait(8'h0F, n);
        wait_idle();
        check("b2b_frames", start_edges.size() - base, 2);
        if (start_edges.size() > base + 1)
            check("b2b_period", start_edges[base+1] - start_edges[base], 10 * BAUD);

        // Full FIFO while CTS holds the transmitter off.
        cts_n = 1'b1;
        repeat (3) step();
        base = start_edges.size();
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44; fb[4] = 8'h99;
        for (int k = 0; k < 5; k++) begin
            push_try(fb[k], acc);
            check($sformatf("full_ready_%0d", k), int'(acc), (k < DEPTH) ? 1 : 0);
        end
        check("full_level", int'(level_out), DEPTH);
        check("full_ready_low", int'(ready_out), 0);
        check("full_no_tx", int'(busy_out), 0);
        cts_n = 1'b0;
        wait_idle();
        check("full_frames", start_edges.size() - base, DEPTH);

        // CTS dropped mid-frame: current frame completes, next one waits.
        base = start_edges.size();
        push_wait(8'hFF, n);
        push_wait(8'h3C, n);
        wait_starts(base + 1);
        s0 = (start_edges.size() > base) ? start_edges[base] : cyc;
        wait_until_cyc(s0 + BAUD + 3 * BAUD + 1);
        cts_n = 1'b1;
        wait_until_cyc(s0 + 10 * BAUD + 20);
        check("cts_hold_frames", start_edges.size() - base, 1);
        check("cts_hold_busy", int'(busy_out), 0);
        check("cts_hold_level", int'(level_out), 1);
        cts_n  = 1'b0;
        r_edge = cyc;
        wait_until_cyc(r_edge + 2);
        check("cts_not_before_3", int'(busy_out), 0);
        step();
        check("cts_start_at_3", int'(busy_out), 1);
        wait_idle();
        check("cts_total_frames", start_edges.size() - base, 2);

        // Asynchronous reset during a data bit that drives the line low.
        base = start_edges.size();
        push_wait(8'hC3, n);
        push_wait(8'h5A, n);
        wait_starts(base + 1);
        s0 = (start_edges.size() > base) ? start_edges[base] : cyc;
        wait_until_cyc(s0 + 13);
        #1;
        check("pre_reset_tx", int'(tx), 0);
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", int'(tx), 1);
        check("async_reset_level", int'(level_out), 0);
        check("async_reset_busy", int'(busy_out), 0);
        sb.delete();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        base = start_edges.size();
        push_wait(8'h81, n);
        wait_idle();
        check("post_reset_frames", start_edges.size() - base, 1);

        // Push coinciding with the STOP-to-START pop keeps the level.
        base = start_edges.size();
        push_wait(8'h01, n);
        push_wait(8'h02, s0);
        push_wait(8'h03, s0);
        wait_until_cyc(n + 10 * BAUD);
        check("pushpop_level_before", int'(level_out), 2);
        push_try(8'h04, acc);
        check("pushpop_accept", int'(acc), 1);
        check("pushpop_level_after", int'(level_out), 2);
        wait_idle();
        check("pushpop_frames", start_edges.size() - base, 4);

        // Randomised bytes, gaps and CTS stalls.
        base = start_edges.size();
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                cts_n = 1'b1;
                repeat ($urandom_range(5, 60)) step();
                cts_n = 1'b0;
            end
            repeat ($urandom_range(0, 3)) step();
            push_wait(8'($urandom_range(0, 255)), n);
        end
        wait_idle();
        check("random_frames", start_edges.size() - base, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
